// File: rtl/ulpi_phy_emu.sv
// ulpi_phy_emu - cycle-accurate PHY-side model of a ULPI link.
//
// Purpose: the responder to a link-side ULPI engine. Host-to-device bytes taken
// from an AXI-stream sink are driven onto ULPI as RX data. Link transmit
// packets are captured onto an AXI-stream source. Link register reads/writes
// are served from an internal register file.
//
// Ports:
//   usb_clock        60 MHz ULPI clock, rising edge
//   arst_n           asynchronous active-low reset (released synchronously inside)
//   ulpi_dir         PHY owns the bus when 1
//   ulpi_nxt         PHY throttle / RX data strobe
//   ulpi_stp         link stop
//   ulpi_data_i      bus value driven by the link
//   ulpi_data_o      bus value driven by the PHY (meaningful only while dir=1
//                    outside turnaround cycles; 0x00 otherwise)
//   s_t*             RX packet sink (host to link)
//   m_t*             TX packet source (link to host); m_tuser=1 marks an abort
//   func_ctrl_o      current value of register 0x04 (Function Control)
//   dbg_state_o      current FSM state encoding
//
// Handshake: on both AXI-stream ports a byte moves on a rising edge where
// tvalid & tready are both 1. The source holds tvalid/tdata/tlast/tuser stable
// until that edge and never withdraws tvalid; s_tready is a combinational
// function of state and s_tvalid, m_tvalid never depends on m_tready.
module ulpi_phy_emu #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009,
  parameter int          TX_LATENCY = 1
) (
  input  logic       usb_clock,
  input  logic       arst_n,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  input  logic       ulpi_stp,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic [7:0] m_tdata,
  output logic [7:0] func_ctrl_o,
  output logic [3:0] dbg_state_o
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RX_TURN = 4'd1;
  localparam logic [3:0] S_RX_DATA = 4'd2;
  localparam logic [3:0] S_RX_END  = 4'd3;
  localparam logic [3:0] S_RX_BACK = 4'd4;
  localparam logic [3:0] S_TX_WAIT = 4'd5;
  localparam logic [3:0] S_TX_DATA = 4'd6;
  localparam logic [3:0] S_RW_DATA = 4'd7;
  localparam logic [3:0] S_RW_STP  = 4'd8;
  localparam logic [3:0] S_RR_TURN = 4'd9;
  localparam logic [3:0] S_RR_DATA = 4'd10;
  localparam logic [3:0] S_RR_BACK = 4'd11;

  localparam logic [1:0] LAT_M1 = 2'(TX_LATENCY - 1);

  // Reset: asserts immediately, releases two edges after arst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge usb_clock or negedge arst_n) begin
    if (!arst_n) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [3:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  // One-byte holdback between the ULPI TX stream and the m port. The last byte
  // is only known to be last when stp arrives, so every byte is held until
  // the next byte (tlast=0) or stp (tlast=1) decides its fate.
  logic [7:0] hold_q;
  logic       hold_v_q;
  logic       hold_fin_q;   // held byte is the final one, waiting for m space
  logic       hold_user_q;

  logic       m_tvalid_q, m_tlast_q, m_tuser_q;
  logic [7:0] m_tdata_q;

  logic [7:0] regs_q [16];  // addresses 0x04..0x13

  logic       dir, nxt, s_ready;
  logic [7:0] dout, rdata;
  logic       tx_take;      // a link byte enters the holdback this cycle
  logic [7:0] tx_byte;
  logic       tx_stp;       // stp seen in TX_DATA this cycle
  logic       reg_we;
  logic       m_free;
  logic       push;
  logic       push_last, push_user;
  logic       addr_in_rf;
  logic [3:0] rf_idx;

  assign m_free     = !m_tvalid_q || m_tready;
  assign addr_in_rf = (addr_q >= 6'h04) && (addr_q <= 6'h13);
  assign rf_idx     = addr_q[3:0] - 4'd4;

  always_comb begin
    rdata = 8'h00;
    case (addr_q)
      6'h00:   rdata = VENDOR_ID[7:0];
      6'h01:   rdata = VENDOR_ID[15:8];
      6'h02:   rdata = PRODUCT_ID[7:0];
      6'h03:   rdata = PRODUCT_ID[15:8];
      default: if (addr_in_rf) rdata = regs_q[rf_idx];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dir     = 1'b0;
    nxt     = 1'b0;
    dout    = 8'h00;
    s_ready = 1'b0;
    tx_take = 1'b0;
    tx_byte = ulpi_data_i;
    tx_stp  = 1'b0;
    reg_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 2'd0;
        // Pending RX pre-empts any command; the link retries it later.
        if (s_tvalid) begin
          state_d = S_RX_TURN;
        end else begin
          case (ulpi_data_i[7:6])
            2'b01: state_d = S_TX_WAIT;
            2'b10: begin
              nxt     = 1'b1;
              addr_d  = ulpi_data_i[5:0];
              state_d = S_RW_DATA;
            end
            2'b11: begin
              nxt     = 1'b1;
              addr_d  = ulpi_data_i[5:0];
              state_d = S_RR_TURN;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RX_TURN: begin
        dir     = 1'b1;
        nxt     = 1'b1;
        state_d = S_RX_DATA;
      end
      S_RX_DATA: begin
        dir = 1'b1;
        if (s_tvalid) begin
          nxt     = 1'b1;
          dout    = s_tdata;
          s_ready = 1'b1;
          if (s_tlast) state_d = S_RX_END;
        end else begin
          dout = 8'h11;  // RX CMD: RxActive=1, LineState=J
        end
      end
      S_RX_END: begin
        dir     = 1'b1;
        dout    = 8'h01;  // RX CMD: RxActive=0
        state_d = S_RX_BACK;
      end
      S_RX_BACK: state_d = S_IDLE;
      S_TX_WAIT: begin
        // Waiting for an empty holdback keeps the previous packet's final
        // byte from being overwritten while the m side is stalled.
        if (cnt_q == LAT_M1) begin
          if (!hold_v_q) begin
            nxt     = 1'b1;
            tx_take = 1'b1;
            tx_byte = {~ulpi_data_i[3:0], ulpi_data_i[3:0]};
            state_d = S_TX_DATA;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_TX_DATA: begin
        if (ulpi_stp) begin
          tx_stp  = 1'b1;
          state_d = S_IDLE;
        end else begin
          nxt     = !hold_v_q || m_free;
          tx_take = nxt;
        end
      end
      S_RW_DATA: begin
        nxt     = 1'b1;
        wdata_d = ulpi_data_i;
        state_d = S_RW_STP;
      end
      S_RW_STP: begin
        if (ulpi_stp) begin
          reg_we  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RR_TURN: begin
        dir     = 1'b1;
        state_d = S_RR_DATA;
      end
      S_RR_DATA: begin
        dir     = 1'b1;
        dout    = rdata;
        state_d = S_RR_BACK;
      end
      S_RR_BACK: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // The held byte leaves when a successor arrives, when stp closes the packet,
  // or later if stp arrived while the m side was stalled.
  assign push      = hold_v_q && m_free && (tx_take || tx_stp || hold_fin_q);
  assign push_last = tx_stp ? 1'b1 : hold_fin_q;
  assign push_user = tx_stp ? (ulpi_data_i == 8'hFF) : hold_user_q;

  always_ff @(posedge usb_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      addr_q      <= 6'd0;
      wdata_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_v_q    <= 1'b0;
      hold_fin_q  <= 1'b0;
      hold_user_q <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      m_tdata_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;

      if (tx_take) begin
        hold_q      <= tx_byte;
        hold_v_q    <= 1'b1;
        hold_fin_q  <= 1'b0;
        hold_user_q <= 1'b0;
      end else if (push) begin
        hold_v_q   <= 1'b0;
        hold_fin_q <= 1'b0;
      end else if (tx_stp) begin
        hold_fin_q  <= 1'b1;
        hold_user_q <= (ulpi_data_i == 8'hFF);
      end

      if (push) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= hold_q;
        m_tlast_q  <= push_last;
        m_tuser_q  <= push_user;
      end else if (m_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge usb_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      regs_q[0] <= 8'h41;  // 0x04 Function Control
      regs_q[6] <= 8'h06;  // 0x0A OTG Control
    end else if (reg_we && addr_in_rf) begin
      regs_q[rf_idx] <= wdata_q;
    end
  end

  assign ulpi_dir    = dir;
  assign ulpi_nxt    = nxt;
  assign ulpi_data_o = dout;
  assign s_tready    = s_ready;
  assign m_tvalid    = m_tvalid_q;
  assign m_tlast     = m_tlast_q;
  assign m_tuser     = m_tuser_q;
  assign m_tdata     = m_tdata_q;
  assign func_ctrl_o = regs_q[0];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// tb_ulpi_phy_emu - table-driven bench for ulpi_phy_emu.
// Each record is one clock cycle: inputs driven just after the rising edge,
// outputs compared on the falling edge against hand-computed values.
module tb_ulpi_phy_emu;

  // ---------------- clock / reset ----------------
  logic       usb_clock = 1'b0;
  logic       arst_n    = 1'b0;
  logic       ulpi_dir, ulpi_nxt, ulpi_stp;
  logic [7:0] ulpi_data_i, ulpi_data_o;
  logic       s_tvalid, s_tready, s_tlast;
  logic [7:0] s_tdata;
  logic       m_tvalid, m_tready, m_tlast, m_tuser;
  logic [7:0] m_tdata, func_ctrl_o;
  logic [3:0] dbg_state;

  always #5 usb_clock = ~usb_clock;

  ulpi_phy_emu dut (
    .usb_clock   (usb_clock),
    .arst_n      (arst_n),
    .ulpi_dir    (ulpi_dir),
    .ulpi_nxt    (ulpi_nxt),
    .ulpi_stp    (ulpi_stp),
    .ulpi_data_i (ulpi_data_i),
    .ulpi_data_o (ulpi_data_o),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tdata     (s_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .m_tdata     (m_tdata),
    .func_ctrl_o (func_ctrl_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- vector records ----------------
  typedef struct {
    string      tag;
    logic [7:0] din;
    logic       stp, sv, sl;
    logic [7:0] sd;
    logic       mr;
    logic       edir, enxt, dchk;
    logic [7:0] edo;
    logic       esr, emv;
    logic [7:0] emd;
    logic       eml, emu;
    logic [7:0] efc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string tag, logic [7:0] din, logic stp, logic sv,
                              logic sl, logic [7:0] sd, logic mr,
                              logic edir, logic enxt, logic dchk, logic [7:0] edo,
                              logic esr, logic emv, logic [7:0] emd, logic eml,
                              logic emu, logic [7:0] efc);
    vec_t v;
    v.tag = tag; v.din = din; v.stp = stp; v.sv = sv; v.sl = sl; v.sd = sd;
    v.mr = mr; v.edir = edir; v.enxt = enxt; v.dchk = dchk; v.edo = edo;
    v.esr = esr; v.emv = emv; v.emd = emd; v.eml = eml; v.emu = emu; v.efc = efc;
    return v;
  endfunction

  // Register read: nxt in IDLE, turnaround, data, back-turnaround.
  task automatic add_read(string tag, logic [7:0] cmd, logic [7:0] exp, logic [7:0] fc);
    tbl.push_back(mk(tag, cmd,   0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, fc));
    tbl.push_back(mk(tag, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, fc));
    tbl.push_back(mk(tag, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, exp,   0, 0, 8'h00, 0, 0, fc));
    tbl.push_back(mk(tag, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, fc));
  endtask

  // Register write: cmd, data, stp. Written value is visible the cycle after stp.
  task automatic add_write(string tag, logic [7:0] cmd, logic [7:0] val, logic [7:0] fc);
    tbl.push_back(mk(tag, cmd,   0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, fc));
    tbl.push_back(mk(tag, val,   0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, fc));
    tbl.push_back(mk(tag, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, fc));
  endtask

  // ---------------- driver + comparison ----------------
  task automatic apply_row(input vec_t v, input int idx);
    logic ok;
    ulpi_data_i = v.din; ulpi_stp = v.stp;
    s_tvalid = v.sv; s_tlast = v.sl; s_tdata = v.sd; m_tready = v.mr;
    @(negedge usb_clock);
    n_vec++;
    ok = (ulpi_dir == v.edir) && (ulpi_nxt == v.enxt) && (s_tready == v.esr) &&
         (m_tvalid == v.emv) && (func_ctrl_o == v.efc) &&
         (!v.dchk || ulpi_data_o == v.edo) &&
         (!v.emv || (m_tdata == v.emd && m_tlast == v.eml && m_tuser == v.emu));
    if (!ok) begin
      n_bad++;
      $display("FAIL row %0d %s: got dir=%0b nxt=%0b do=%02h srdy=%0b m=%0b/%02h/%0b/%0b fc=%02h; want dir=%0b nxt=%0b do=%02h(chk=%0b) srdy=%0b m=%0b/%02h/%0b/%0b fc=%02h",
               idx, v.tag, ulpi_dir, ulpi_nxt, ulpi_data_o, s_tready, m_tvalid, m_tdata,
               m_tlast, m_tuser, func_ctrl_o, v.edir, v.enxt, v.edo, v.dchk, v.esr,
               v.emv, v.emd, v.eml, v.emu, v.efc);
    end
    @(posedge usb_clock);
    #1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply_row(tbl[i], i);
    tbl.delete();
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ulpi_data_i = 8'h00; ulpi_stp = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tdata = 8'h00; m_tready = 1'b1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge usb_clock);
    arst_n = 1'b1;
    repeat (4) @(posedge usb_clock);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    drive_idle();
    repeat (3) @(posedge usb_clock);
    #2;
    // Reset state
    check("rst_dir",   {7'd0, ulpi_dir}, 8'h00);
    check("rst_nxt",   {7'd0, ulpi_nxt}, 8'h00);
    check("rst_do",    ulpi_data_o, 8'h00);
    check("rst_m",     {5'd0, s_tready, m_tvalid, m_tlast}, 8'h00);
    check("rst_tuser", {7'd0, m_tuser}, 8'h00);
    check("rst_fc",    func_ctrl_o, 8'h41);
    check("rst_state", {4'd0, dbg_state}, 8'h00);
    release_reset();

    // Fields: tag, din, stp, sv, sl, sd, mr | dir, nxt, dchk, do, srdy, mv, md, ml, mu, fc
    tbl.push_back(mk("idle", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h41));
    add_read("rd01", 8'hC1, 8'h04, 8'h41);
    add_read("rd00", 8'hC0, 8'h24, 8'h41);
    add_read("rd02", 8'hC2, 8'h09, 8'h41);
    add_read("rd03", 8'hC3, 8'h00, 8'h41);
    add_read("rd0a", 8'hCA, 8'h06, 8'h41);
    add_read("rd20", 8'hE0, 8'h00, 8'h41);
    add_read("rd04", 8'hC4, 8'h41, 8'h41);
    add_write("wr04", 8'h84, 8'h55, 8'h41);
    add_read("rb04", 8'hC4, 8'h55, 8'h55);
    add_write("wr00", 8'h80, 8'h99, 8'h55);
    add_read("rb00", 8'hC0, 8'h24, 8'h55);
    // Write to 0x13 with stp arriving one cycle late
    tbl.push_back(mk("wr13", 8'h93, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("wr13", 8'h3C, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("wr13", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("wr13", 8'h00, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    add_read("rb13", 8'hD3, 8'h3C, 8'h55);
    add_write("wr14", 8'h94, 8'h77, 8'h55);
    add_read("rb14", 8'hD4, 8'h00, 8'h55);
    // Transmit PID 3, bytes 11 22, stp with 00, m always ready
    tbl.push_back(mk("tx",   8'h43, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("tx",   8'h43, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("tx",   8'h11, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("tx",   8'h22, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 8'h55));
    tbl.push_back(mk("tx",   8'h00, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h11, 0, 0, 8'h55));
    tbl.push_back(mk("tx",   8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h22, 1, 0, 8'h55));
    tbl.push_back(mk("tx",   8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    // Same transmit, m stalled 5 cycles mid-packet, aborted with stp+FF
    tbl.push_back(mk("txbp", 8'h43, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("txbp", 8'h43, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("txbp", 8'h11, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk("txbp", 8'h22, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 8'h55));
    tbl.push_back(mk("txbp", 8'h22, 0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 8'h55));
    tbl.push_back(mk("txbp", 8'hFF, 1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h11, 0, 0, 8'h55));
    tbl.push_back(mk("txbp", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h22, 1, 1, 8'h55));
    tbl.push_back(mk("txbp", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    // PID A, one byte, stp while m is stalled: last byte leaves after the stall
    tbl.push_back(mk("txst", 8'h4A, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h4A, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h77, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 8'h77, 1, 0, 8'h55));
    tbl.push_back(mk("txst", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    // RX A5, gap of 2, 12, 34(last)
    tbl.push_back(mk("rx",   8'h00, 0, 1, 0, 8'hA5, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 1, 0, 8'hA5, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 1, 0, 8'hA5, 1, 1, 1, 1, 8'hA5, 1, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 1, 0, 8'h12, 1, 1, 1, 1, 8'h12, 1, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 1, 1, 8'h34, 1, 1, 1, 1, 8'h34, 1, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h01, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rx",   8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    // RX and TX CMD in the same IDLE cycle: RX wins; stp under dir=1 ignored
    tbl.push_back(mk("rxtx", 8'h43, 0, 1, 1, 8'h5A, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rxtx", 8'h43, 0, 1, 1, 8'h5A, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rxtx", 8'h43, 1, 1, 1, 8'h5A, 1, 1, 1, 1, 8'h5A, 1, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rxtx", 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h01, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rxtx", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rxtx", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    run_tbl();

    // Reset mid-TX with a byte waiting on a stalled m port
    tbl.push_back(mk("rsttx", 8'h43, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rsttx", 8'h43, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rsttx", 8'h11, 0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h55));
    tbl.push_back(mk("rsttx", 8'h22, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1, 8'hC3, 0, 0, 8'h55));
    run_tbl();
    ulpi_data_i = 8'h22;
    arst_n = 1'b0;
    #1;
    check("rsttx_mvalid", {7'd0, m_tvalid}, 8'h00);
    check("rsttx_nxt",    {7'd0, ulpi_nxt}, 8'h00);
    check("rsttx_fc",     func_ctrl_o, 8'h41);
    drive_idle();
    release_reset();
    tbl.push_back(mk("posttx", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h41));
    tbl.push_back(mk("posttx", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h41));
    add_read("postrd", 8'hC4, 8'h41, 8'h41);
    run_tbl();

    // Reset mid-RX
    tbl.push_back(mk("rstrx", 8'h00, 0, 1, 0, 8'h66, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h41));
    tbl.push_back(mk("rstrx", 8'h00, 0, 1, 0, 8'h66, 1, 1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h41));
    tbl.push_back(mk("rstrx", 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 8'h41));
    run_tbl();
    s_tvalid = 1'b1; s_tdata = 8'h66;
    arst_n = 1'b0;
    #1;
    check("rstrx_dir_now",  {7'd0, ulpi_dir}, 8'h00);
    check("rstrx_nxt_now",  {7'd0, ulpi_nxt}, 8'h00);
    check("rstrx_srdy_now", {7'd0, s_tready}, 8'h00);
    @(posedge usb_clock);
    #1;
    check("rstrx_dir_edge", {7'd0, ulpi_dir}, 8'h00);
    check("rstrx_nxt_edge", {7'd0, ulpi_nxt}, 8'h00);
    check("rstrx_do_edge",  ulpi_data_o, 8'h00);
    drive_idle();
    release_reset();
    tbl.push_back(mk("postrx", 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h41));
    run_tbl();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
